// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: loader states, default parameters and a sizing helper
package fpga_cfg_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PRE,
    LOAD,
    WRITE,
    SETTLE_FF,
    SETTLE_RDY,
    DONE,
    ERR
  } cfg_state_t;
  localparam int DEF_CFG_W = 224;
  localparam int DEF_NUM_SLICES = 245;
  localparam int DEF_PRE_CYCLES = 10;
  localparam int DEF_SETTLE_CYCLES = 10;
  localparam bit DEF_PARTIAL_OK = 1'b1;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/fpga_config_loader_timer.sv
// cfg_delay_timer: loadable down-counter that saturates at zero and flags done there
module cfg_delay_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         count,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? value : (count && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clock) cnt_q <= rst ? '0 : cnt_d;
  assign done = cnt_q == '0;
endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: streams configuration words into one-hot fabric slices, then sequences ff_en and rdy
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_W         = DEF_CFG_W,
  parameter int NUM_SLICES    = DEF_NUM_SLICES,
  parameter int PRE_CYCLES    = DEF_PRE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter bit PARTIAL_OK    = DEF_PARTIAL_OK
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cfg_valid,
  input  logic [CFG_W-1:0]      cfg_data,
  input  logic                  cfg_last,
  output logic                  cfg_ready,
  output logic [CFG_W-1:0]      configs_in,
  output logic [NUM_SLICES-1:0] configs_en,
  output logic                  ff_en,
  output logic                  rdy,
  output logic                  busy,
  output logic                  err
);
  localparam int KW = $clog2(NUM_SLICES + 1);
  localparam int CW = max2(1, $clog2(max2(PRE_CYCLES, SETTLE_CYCLES) + 1));
  localparam int PL = PRE_CYCLES > 0 ? PRE_CYCLES - 1 : 0;
  localparam int SL = SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0;
  cfg_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d, k_inc;
  logic [CFG_W-1:0] configs_in_q, configs_in_d;
  logic [NUM_SLICES-1:0] configs_en_q, configs_en_d;
  logic last_q, last_d, ff_en_q, ff_en_d, rdy_q, rdy_d, err_q, err_d;
  logic cfg_ready_q, cfg_ready_d, busy_q, busy_d;
  logic t_load, t_count, t_done, full, early;
  logic [CW-1:0] t_val;
  cfg_delay_timer #(.W(CW)) u_timer (
    .clock(clock),
    .rst  (rst),
    .load (t_load),
    .value(t_val),
    .count(t_count),
    .done (t_done)
  );
  assign k_inc = k_q + 1'b1;
  assign full  = k_inc == KW'(NUM_SLICES);
  assign early = last_q && !full && !PARTIAL_OK;
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    last_d       = last_q;
    configs_in_d = configs_in_q;
    ff_en_d      = ff_en_q;
    rdy_d        = rdy_q;
    err_d        = err_q;
    t_load       = 1'b0;
    t_count      = 1'b0;
    t_val        = CW'(PL);
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = PRE_CYCLES == 0 ? LOAD : PRE;
        k_d     = '0;
        err_d   = 1'b0;
        ff_en_d = 1'b0;
        rdy_d   = 1'b0;
        t_load  = 1'b1;
      end
      PRE: if (t_done) state_d = LOAD; else t_count = 1'b1;
      LOAD: if (cfg_valid && cfg_ready_q) begin
        configs_in_d = cfg_data;
        last_d       = cfg_last;
        state_d      = WRITE;
      end
      WRITE: begin
        k_d     = k_inc;
        t_load  = 1'b1;
        t_val   = CW'(SL);
        state_d = (last_q || full) ? (early ? ERR : SETTLE_FF) : LOAD;
        err_d   = early;
      end
      SETTLE_FF: if (t_done) begin
        ff_en_d = 1'b1;
        state_d = SETTLE_RDY;
        t_load  = 1'b1;
        t_val   = CW'(SL);
      end else t_count = 1'b1;
      SETTLE_RDY: if (t_done) begin
        rdy_d   = 1'b1;
        state_d = DONE;
      end else t_count = 1'b1;
      default: state_d = IDLE;
    endcase
    cfg_ready_d  = state_d == LOAD;
    busy_d       = state_d inside {PRE, LOAD, WRITE, SETTLE_FF, SETTLE_RDY};
    configs_en_d = state_d == WRITE ? NUM_SLICES'(1) << k_d : '0;
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      last_q       <= 1'b0;
      configs_in_q <= '0;
      configs_en_q <= '0;
      ff_en_q      <= 1'b0;
      rdy_q        <= 1'b0;
      err_q        <= 1'b0;
      cfg_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      last_q       <= last_d;
      configs_in_q <= configs_in_d;
      configs_en_q <= configs_en_d;
      ff_en_q      <= ff_en_d;
      rdy_q        <= rdy_d;
      err_q        <= err_d;
      cfg_ready_q  <= cfg_ready_d;
      busy_q       <= busy_d;
    end
  end
  assign cfg_ready  = cfg_ready_q;
  assign configs_in = configs_in_q;
  assign configs_en = configs_en_q;
  assign ff_en      = ff_en_q;
  assign rdy        = rdy_q;
  assign busy       = busy_q;
  assign err        = err_q;
endmodule

// File: doc/fpga_config_loader.md
FPGA_CONFIG_LOADER -- requirements
Module: fpga_config_loader

Interface
REQ-001 The block SHALL have one clock, clock, and a synchronous, active-high reset, rst; all state SHALL update on the rising edge of clock.
REQ-002 Parameter CFG_W, default 224, SHALL set the configuration word width.
REQ-003 Parameter NUM_SLICES, default 245, SHALL set the number of configuration slices (one-hot enable width).
REQ-004 Parameter PRE_CYCLES, default 10, SHALL set the idle cycles between start and the first word accept.
REQ-005 Parameter SETTLE_CYCLES, default 10, SHALL set each post-load delay (before ff_en, then before rdy).
REQ-006 Parameter PARTIAL_OK, default 1, SHALL decide whether an early cfg_last is legal (1) or an error (0).
REQ-007 The ports SHALL be as follows (name, direction, width, meaning):
- clock  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a load
- cfg_valid  in  1  cfg_data valid
- cfg_data  in  CFG_W  configuration word
- cfg_last  in  1  final word of the stream
- cfg_ready  out  1  loader accepts a word this cycle
- configs_in  out  CFG_W  registered word to the fabric
- configs_en  out  NUM_SLICES  one-hot slice write strobe
- ff_en  out  1  fabric flip-flop enable
- rdy  out  1  configured fabric ready
- busy  out  1  load in progress
- err  out  1  sticky load error

Function
REQ-008 The FSM SHALL have the states IDLE, PRE, LOAD, WRITE, SETTLE_FF, SETTLE_RDY, DONE and ERR.
REQ-009 IDLE, DONE or ERR with start=1 SHALL go to PRE, clear slice index k, clear err, and drop ff_en and rdy on the next cycle.
REQ-010 start SHALL be ignored in PRE, LOAD, WRITE, SETTLE_FF and SETTLE_RDY.
REQ-011 PRE SHALL last exactly PRE_CYCLES cycles, then go to LOAD; PRE_CYCLES=0 SHALL go straight to LOAD.
REQ-012 cfg_ready SHALL be 1 only in LOAD.
REQ-013 A word SHALL be accepted when cfg_valid and cfg_ready are both 1 in the same cycle.
REQ-014 On accept, configs_in SHALL register cfg_data and the FSM SHALL go to WRITE.
REQ-015 configs_in SHALL hold its value in all other cycles.
REQ-016 In WRITE, configs_en SHALL equal 1<<k for exactly one cycle, and k SHALL increment at the end of WRITE.
REQ-017 configs_en SHALL be all-zero in every state other than WRITE.
REQ-018 Sustained throughput SHALL be one word per two cycles.
REQ-019 Leaving WRITE SHALL go to SETTLE_FF if the accepted word had cfg_last=1 or k+1 equals NUM_SLICES; otherwise it SHALL return to LOAD.
REQ-020 cfg_last on word k+1<NUM_SLICES SHALL, with PARTIAL_OK=0, go to ERR (still performing its WRITE) and set err.
REQ-021 SETTLE_FF SHALL last SETTLE_CYCLES cycles, then assert ff_en.
REQ-022 SETTLE_RDY SHALL last SETTLE_CYCLES cycles, then assert rdy and enter DONE.
REQ-023 ff_en and rdy SHALL hold 1 in DONE until the next start or rst.
REQ-024 busy SHALL be 1 in PRE, LOAD, WRITE, SETTLE_FF and SETTLE_RDY, and 0 otherwise.
REQ-025 After the final word, cfg_ready SHALL stay 0; surplus words SHALL be left unaccepted and have no effect.
REQ-026 In ERR, ff_en and rdy SHALL be 0 and err SHALL be 1 until start or rst.
REQ-027 Index k and the delay counter SHALL be $clog2(NUM_SLICES+1) and $clog2(max(PRE_CYCLES,SETTLE_CYCLES)+1) bits wide and SHALL never wrap.

Reset
REQ-028 While rst=1 the block SHALL enter IDLE.
REQ-029 While rst=1, configs_in, configs_en, ff_en, rdy, busy, err, cfg_ready, k and the counters SHALL all be 0.
REQ-030 rst SHALL take priority over start and over any in-flight WRITE, including a reset mid-load.

Structure
REQ-031 The state enum and default parameter constants SHALL live in package fpga_cfg_pkg.
REQ-032 The PRE and SETTLE delays SHALL use one reusable down-counter sub-module, cfg_delay_timer (load, count, done).

Verification
REQ-033 The bench SHALL use CFG_W=8, NUM_SLICES=4, PRE_CYCLES=2 and SETTLE_CYCLES=3, and SHALL cover the following scenarios.
REQ-034 Full load: start, then words 0x11, 0x22, 0x33, 0x44 with cfg_valid held -> configs_en pulses 0001, 0010, 0100, 1000 with configs_in matching; ff_en rises 3 cycles after the last WRITE and rdy 3 cycles later.
REQ-035 Early cfg_last with PARTIAL_OK=1: 2 words, the second with cfg_last -> only en bits 0 and 1 pulse; DONE is reached and err=0.
REQ-036 Early cfg_last with PARTIAL_OK=0: same stimulus -> ERR, err=1, ff_en=0, rdy=0; a later start clears err.
REQ-037 Backpressure: cfg_valid toggles 1,0,0,1 -> no strobe without accept; configs_in is stable while idle; start during LOAD is ignored.
REQ-038 Reset mid-load: rst asserted in WRITE of word 2 -> the next cycle shows all outputs 0 and IDLE; surplus words after DONE are not accepted.
